// File: rtl/xpb_lut_acc.sv
// Runtime-loadable multi-channel lookup table with a registered adder tree.
// Optional macro XPB_LUT_CH_OUT_EN exposes the per-channel entries aligned with out_sum.
module xpb_lut_acc #(
    parameter int DATA_W = 1024,
    parameter int IDX_W  = 5,
    parameter int NUM_CH = 4,
    parameter int SUM_W  = DATA_W + $clog2(NUM_CH)
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         clr,
    input  logic                                         ld_valid,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ld_ch,
    input  logic [IDX_W-1:0]                             ld_idx,
    input  logic [DATA_W-1:0]                            ld_data,
    output logic                                         tbl_ready,
    input  logic                                         in_valid,
    input  logic [NUM_CH*IDX_W-1:0]                      in_idx,
    output logic                                         out_valid,
    output logic [SUM_W-1:0]                             out_sum,
    output logic                                         err_notready
`ifdef XPB_LUT_CH_OUT_EN
    ,
    output logic [NUM_CH*DATA_W-1:0]                     out_ch_data
`endif
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TOTAL   = NUM_CH * ENTRIES;
    localparam int CNT_W   = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

    typedef enum logic {EMPTY, READY} tbl_state_t;

    tbl_state_t          state_q, state_d;
    logic [DATA_W-1:0]   mem [NUM_CH][ENTRIES];
    logic [ENTRIES-1:0]  loaded_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ld_fire;
    logic                ld_new;

    logic [DATA_W-1:0]   ent_p1 [NUM_CH];
    logic                vld_p1;
    logic                err_p1;
    logic [SUM_W-1:0]    sum_c;
    logic [SUM_W-1:0]    sum_p2;
    logic                vld_p2;

    // clr has priority over a simultaneous load; out-of-range channels never write
    assign ld_fire = ld_valid && !clr && ({1'b0, ld_ch} < CH_LIMIT);
    assign ld_new  = ld_fire && !loaded_q[ld_ch][ld_idx];

    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem[ld_ch][ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                loaded_q[c] <= '0;
            end
        end else if (ld_fire) begin
            loaded_q[ld_ch][ld_idx] <= 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (ld_new) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Table state: decided from the post-load count so READY shows the cycle after the last load
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (cnt_d == CNT_FULL) state_d = READY;
            READY:   if (clr) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    assign tbl_ready = (state_q == READY);

    // Stage p1: capture the selected entry of every channel
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid && tbl_ready;
            err_p1 <= in_valid && !tbl_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && tbl_ready) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ent_p1[c] <= loaded_q[c][in_idx[c*IDX_W +: IDX_W]] ?
                             mem[c][in_idx[c*IDX_W +: IDX_W]] : '0;
            end
        end
    end

    assign err_notready = err_p1;

    // Stage p2: unsigned sum of all channels, held while no new result arrives
    always_comb begin
        sum_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_c = sum_c + SUM_W'(ent_p1[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            sum_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sum_p2 <= sum_c;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_sum   = sum_p2;

`ifdef XPB_LUT_CH_OUT_EN
    logic [NUM_CH*DATA_W-1:0] ch_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_p2 <= '0;
        end else if (vld_p1) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ch_p2[c*DATA_W +: DATA_W] <= ent_p1[c];
            end
        end
    end

    assign out_ch_data = ch_p2;
`endif

endmodule

// File: tb/tb_xpb_lut_acc.sv
// Scoreboard bench for xpb_lut_acc: random and directed stimulus against a table-level model.
module tb_xpb_lut_acc;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 2;
    localparam int NUM_CH = 3;
    localparam int SUM_W  = DATA_W + $clog2(NUM_CH);
    localparam int CH_W   = 2;
    localparam int ENT    = 1 << IDX_W;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     clr;
    logic                     ld_valid;
    logic [CH_W-1:0]          ld_ch;
    logic [IDX_W-1:0]         ld_idx;
    logic [DATA_W-1:0]        ld_data;
    logic                     tbl_ready;
    logic                     in_valid;
    logic [NUM_CH*IDX_W-1:0]  in_idx;
    logic                     out_valid;
    logic [SUM_W-1:0]         out_sum;
    logic                     err_notready;
`ifdef XPB_LUT_CH_OUT_EN
    logic [NUM_CH*DATA_W-1:0] out_ch_data;
`endif

    xpb_lut_acc #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_CH(NUM_CH), .SUM_W(SUM_W)
    ) u_dut (
        .clk(clk), .reset(reset), .clr(clr),
        .ld_valid(ld_valid), .ld_ch(ld_ch), .ld_idx(ld_idx), .ld_data(ld_data),
        .tbl_ready(tbl_ready),
        .in_valid(in_valid), .in_idx(in_idx),
        .out_valid(out_valid), .out_sum(out_sum), .err_notready(err_notready)
`ifdef XPB_LUT_CH_OUT_EN
        , .out_ch_data(out_ch_data)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SUM_W-1:0]         sum;
        logic [NUM_CH*DATA_W-1:0] ch;
        int                       due;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   rst_cyc = -1;
    int   n_checks = 0;
    int   n_fail = 0;

    // Table model: contents plus one loaded flag per entry
    logic [DATA_W-1:0] m_mem [NUM_CH][ENT];
    bit                m_loaded [NUM_CH][ENT];

    function automatic bit all_loaded();
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < ENT; i++)
                if (!m_loaded[c][i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Evaluate the current inputs against the model, then advance one clock
    task automatic step();
        if (reset) begin
            rst_cyc = cyc + 1;
        end else if (in_valid) begin
            if (all_loaded()) begin
                exp_t e;
                e.sum = '0;
                e.ch  = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    logic [DATA_W-1:0] v;
                    int ix;
                    ix = int'(in_idx[c*IDX_W +: IDX_W]);
                    v  = m_loaded[c][ix] ? m_mem[c][ix] : '0;
                    e.sum = e.sum + SUM_W'(v);
                    e.ch[c*DATA_W +: DATA_W] = v;
                end
                e.due = cyc + 2;
                exp_q.push_back(e);
            end else begin
                err_q.push_back(cyc + 1);
            end
        end
        @(posedge clk);
        if (reset || clr) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int i = 0; i < ENT; i++)
                    m_loaded[c][i] = 1'b0;
        end else if (ld_valid && int'(ld_ch) < NUM_CH) begin
            m_mem[ld_ch][ld_idx]    = ld_data;
            m_loaded[ld_ch][ld_idx] = 1'b1;
        end
        #1;
    endtask

    task automatic drive(input bit lv, input int lch, input int lidx, input logic [DATA_W-1:0] d,
                         input bit iv, input logic [NUM_CH*IDX_W-1:0] ix, input bit c);
        ld_valid = lv;
        ld_ch    = CH_W'(lch);
        ld_idx   = IDX_W'(lidx);
        ld_data  = d;
        in_valid = iv;
        in_idx   = ix;
        clr      = c;
        step();
    endtask

    function automatic logic [NUM_CH*IDX_W-1:0] pack(input int a, input int b, input int c2);
        return {IDX_W'(c2), IDX_W'(b), IDX_W'(a)};
    endfunction

    // Monitor: pops the scoreboard whenever a result or error pulse is due
    logic [SUM_W-1:0]         last_sum = '0;
    logic [NUM_CH*DATA_W-1:0] last_ch = '0;

    always @(negedge clk) begin
        bit ev;
        bit ee;
        if (rst_cyc == cyc) begin
            exp_q.delete();
            err_q.delete();
            last_sum = '0;
            last_ch  = '0;
        end
        check("tbl_ready", 64'(tbl_ready), 64'(all_loaded()));
        ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
            exp_t e;
            e = exp_q.pop_front();
            last_sum = e.sum;
            last_ch  = e.ch;
        end
        check("out_sum", 64'(out_sum), 64'(last_sum));
`ifdef XPB_LUT_CH_OUT_EN
        check("out_ch_data", 64'(out_ch_data), 64'(last_ch));
`endif
        ee = (err_q.size() > 0) && (err_q[0] == cyc);
        check("err_notready", 64'(err_notready), 64'(ee));
        if (ee) void'(err_q.pop_front());
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, '0, 0, '0, 0);
        drive(0, 0, 0, '0, 0, '0, 0);
        reset = 1'b0;
        drive(0, 0, 0, '0, 0, '0, 0);

        // Lookup on an empty table is dropped with an error pulse
        drive(0, 0, 0, '0, 1, pack(1, 2, 3), 0);

        // Fill the table; a rewrite before the final load must not complete it
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < ENT; i++) begin
                if (c == NUM_CH - 1 && i == ENT - 1) begin
                    drive(1, 0, 0, 16'h0000, 0, '0, 0);
                    drive(0, 0, 0, '0, 1, pack(0, 0, 0), 0);
                end
                drive(1, c, i, 16'(16'h0100 * c + i), 0, '0, 0);
            end
        end
        drive(0, 0, 0, '0, 0, '0, 0);

        // Single then back-to-back lookups
        drive(0, 0, 0, '0, 1, pack(3, 2, 1), 0);
        drive(0, 0, 0, '0, 0, '0, 0);
        drive(0, 0, 0, '0, 0, '0, 0);
        drive(0, 0, 0, '0, 1, pack(0, 1, 2), 0);
        drive(0, 0, 0, '0, 1, pack(3, 3, 3), 0);
        drive(0, 0, 0, '0, 1, pack(2, 0, 1), 0);
        drive(0, 0, 0, '0, 1, pack(1, 3, 0), 0);

        // Same-cycle load and lookup returns the old value, the next lookup the new one
        drive(1, 0, 3, 16'hFFFF, 1, pack(3, 0, 0), 0);
        drive(0, 0, 0, '0, 1, pack(3, 0, 0), 0);

        // Out-of-range channel load is ignored
        drive(1, 3, 1, 16'h1234, 0, '0, 0);
        drive(0, 0, 0, '0, 1, pack(1, 1, 1), 0);

        // clr behind an in-flight lookup, with a load in the clr cycle dropped
        drive(0, 0, 0, '0, 1, pack(2, 2, 2), 0);
        drive(1, 0, 0, 16'hAAAA, 0, '0, 1);
        drive(0, 0, 0, '0, 1, pack(0, 0, 0), 0);
        drive(0, 0, 0, '0, 0, '0, 0);

        // All-ones table: widest possible sum
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < ENT; i++)
                drive(1, c, i, 16'hFFFF, 0, '0, 0);
        drive(0, 0, 0, '0, 1, pack(0, 1, 2), 0);
        drive(0, 0, 0, '0, 1, pack(3, 3, 3), 0);
        drive(0, 0, 0, '0, 0, '0, 0);
        drive(0, 0, 0, '0, 0, '0, 0);

        // Reset with lookups in flight squashes them
        drive(0, 0, 0, '0, 1, pack(1, 1, 1), 0);
        reset = 1'b1;
        drive(0, 0, 0, '0, 1, pack(2, 2, 2), 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) drive(0, 0, 0, '0, 0, '0, 0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), int'($urandom_range(0, ENT - 1)),
                  DATA_W'($urandom), bit'($urandom_range(0, 1)), (NUM_CH*IDX_W)'($urandom),
                  ($urandom_range(0, 199) == 0));
        end

        for (int k = 0; k < 4; k++) drive(0, 0, 0, '0, 0, '0, 0);
        check("drain_results", 64'(exp_q.size()), 64'(0));
        check("drain_errors", 64'(err_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
